addroundkey_stage: RTL and testbench
====================================

# addroundkey_stage

Registered AddRoundKey stage sitting directly downstream of `mixcolumns_top` in the AES-128 round datapath. Each accepted beat is XORed with the current round key and registered:
- Normal rounds use the 128-bit MixColumns result.
- The final round uses the pre-MixColumns (ShiftRows) state, since AES skips MixColumns in round NR.

The block tracks the round number internally and tags each output beat. A valid/ready handshake with a 2-entry skid buffer gives full throughput with registered backpressure.

## Interface
Parameters:
- `NR`, 10, number of AES rounds; round counter range is 1..NR.

Ports:
- `clk`  in  1  rising-edge clock; the block has one clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  synchronous pulse; restarts round numbering at 1.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  stage can accept a beat.
- `mc_in`  in  128  MixColumns output; byte 0 is in [127:120].
- `sr_in`  in  128  ShiftRows output, i.e. the MixColumns input; used in round NR.
- `round_key`  in  128  round key for the beat being accepted.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts.
- `out_state`  out  128  round result.
- `out_round`  out  4  round number of the output beat.
- `out_last`  out  1  high when `out_round == NR`.

## Operation
- Transfer occurs on a rising `clk` edge when both valid and ready are high.
- Round counter `rnd` (4 bits):
  - Reset value is 1.
  - Increments on each input transfer; wraps from NR to 1.
- Data selection per accepted beat:
  - If `rnd == NR`: `d = sr_in ^ round_key`.
  - Otherwise: `d = mc_in ^ round_key`.
  - The beat is tagged with `rnd` and `last = (rnd == NR)`.
- `start` behaviour:
  - `start` alone sets `rnd` to 1 at the next edge.
  - `start` coincident with a transfer: the beat is tagged round 1 and uses `mc_in`; `rnd` becomes 2.
  - `start` has priority over the wrap.
- Buffer: an output register (OUT) plus a skid register (SKID), each with a valid bit.
  - `in_ready = rst_n & ~skid_valid`, driven directly from a flop and `rst_n`.
  - Accept while OUT is empty or draining: the beat goes to OUT.
  - Accept while OUT is full and stalled: the beat goes to SKID.
  - When OUT drains and SKID is full: SKID moves to OUT, and SKID empties.
  - Simultaneous OUT drain and SKID full with `in_ready` low: no accept; SKID moves to OUT.
- Ordering is strictly FIFO; no beat is dropped or duplicated.
- Outputs are stable while `out_valid & ~out_ready`.

## Timing
- Latency: 1 cycle from input transfer to `out_valid` when the stage is empty.
- Throughput: 1 beat/cycle while `out_ready` is held high.
- After `out_ready` deasserts:
  - At most 1 further beat is accepted (into SKID).
  - `in_ready` drops on the following cycle.
- `in_ready` returns high the cycle after SKID moves into OUT.
- Reset, asynchronous, while `rst_n` is low:
  - `out_valid = 0`, `out_state = 0`, `out_round = 0`, `out_last = 0`.
  - `in_ready = 0`; SKID is empty and its data is 0.
  - `rnd = 1`.
  - `in_ready` rises combinationally when `rst_n` deasserts.
- Reset mid-operation discards both buffered beats and restores the counter to 1.

## Configuration
- `ADDRK_ZEROIZE_EN` defined:
  - When OUT drains with no replacement beat, `out_state`, `out_round` and `out_last` clear to 0 at that edge.
  - When SKID moves into OUT, the SKID data clears to 0.
  - No key-mixed state lingers in idle registers.
- `ADDRK_ZEROIZE_EN` undefined:
  - Registers hold their last data when invalid.
  - Only valid bits change.

## Test plan
- **Round-1 vector:**
  - Stimulus: `start` with `mc_in=046681e5e0cb199a48f8d37a2806264c`, `round_key=a0fafe1788542cb123a339392a6c7605`.
  - Response: next cycle `out_state=a49c7ff2689f352b6b5bea43026a5049`, `out_round=1`, `out_last=0`.
- **Final-round select:**
  - Stimulus: advance to `rnd=10`, then `sr_in=e9317db5cb322c723d2e895faf090794`, `mc_in=ffff…ff`, `round_key=d014f9a8c9ee2589e13f0cc8b6630ca6`.
  - Response: `out_state=3925841d02dc09fbdc118597196a0b32`, `out_round=10`, `out_last=1`.
  - The next beat is tagged round 1.
- **Backpressure:**
  - Stimulus: 4 back-to-back beats, with `out_ready` low for cycles 2–5.
  - Response: exactly 2 beats accepted before `in_ready` falls; all 4 beats emerge in order with rounds 1–4.
- **Start priority:**
  - Stimulus: `start` asserted together with the 7th beat.
  - Response: that beat is tagged round 1 and the following beat round 2.
- **Mid-stream reset:**
  - Stimulus: pull `rst_n` low with OUT and SKID both full.
  - Response: all outputs 0 immediately; after release, the first beat is tagged round 1.
- **Zeroize (build with `ADDRK_ZEROIZE_EN`):**
  - Stimulus: a single beat drained, then idle.
  - Response: `out_state` reads 0 the cycle after the drain.
  - Without the macro, it holds the drained value.

Source files
------------

// File: rtl/addroundkey_stage.sv
// AES-128 AddRoundKey stage: XORs each accepted beat with the round key and tags it with its round number.
// Latency: 1 cycle from input transfer to out_valid when empty; 1 beat/cycle sustained throughput.
// Backpressure: 2-entry (OUT + SKID) buffer; in_ready comes straight from a flop, so at most 1 beat lands after out_ready drops.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 restart round numbering at 1 (beat with start is round 1, uses mc_in)
//   in_valid / in_ready   input handshake; mc_in, sr_in, round_key sampled on transfer
//   out_valid / out_ready output handshake; out_state, out_round, out_last
// Build option: define ADDRK_ZEROIZE_EN to clear data registers whenever they become invalid.
module addroundkey_stage #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] mc_in,
  input  logic [127:0] sr_in,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [3:0]   out_round,
  output logic         out_last
);

  localparam logic [3:0] NR4 = 4'(NR);

  logic [3:0]   rnd;
  logic         skid_valid;
  logic [127:0] skid_state;
  logic [3:0]   skid_round;
  logic         skid_last;

  logic         acc;
  logic         out_free;
  logic [3:0]   tag;
  logic         use_sr;
  logic         beat_last;
  logic [127:0] beat_state;
  logic [3:0]   rnd_nxt;

  // skid_valid is a flop, so in_ready never depends on out_ready combinationally
  assign in_ready = rst_n & ~skid_valid;
  assign acc      = in_valid & in_ready;
  // OUT can take a new value this edge: it is empty or being consumed
  assign out_free = ~out_valid | out_ready;

  // start forces round 1, which always takes the MixColumns path
  assign tag        = start ? 4'd1 : rnd;
  assign use_sr     = ~start & (rnd == NR4);
  assign beat_state = (use_sr ? sr_in : mc_in) ^ round_key;
  assign beat_last  = (tag == NR4);

  // start outranks the NR -> 1 wrap because tag already reflects it
  always_comb begin
    rnd_nxt = rnd;
    if (acc) begin
      rnd_nxt = beat_last ? 4'd1 : tag + 4'd1;
    end else if (start) begin
      rnd_nxt = 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd <= 4'd1;
    end else begin
      rnd <= rnd_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_state  <= '0;
      out_round  <= '0;
      out_last   <= 1'b0;
      skid_valid <= 1'b0;
      skid_state <= '0;
      skid_round <= '0;
      skid_last  <= 1'b0;
    end else begin
      if (out_free) begin
        if (skid_valid) begin
          // in_ready is low here, so nothing is accepted this edge
          out_valid  <= 1'b1;
          out_state  <= skid_state;
          out_round  <= skid_round;
          out_last   <= skid_last;
          skid_valid <= 1'b0;
`ifdef ADDRK_ZEROIZE_EN
          skid_state <= '0;
          skid_round <= '0;
          skid_last  <= 1'b0;
`endif
        end else if (acc) begin
          out_valid <= 1'b1;
          out_state <= beat_state;
          out_round <= tag;
          out_last  <= beat_last;
        end else begin
          out_valid <= 1'b0;
`ifdef ADDRK_ZEROIZE_EN
          out_state <= '0;
          out_round <= '0;
          out_last  <= 1'b0;
`endif
        end
      end else if (acc) begin
        // OUT is stalled: park the beat in SKID
        skid_valid <= 1'b1;
        skid_state <= beat_state;
        skid_round <= tag;
        skid_last  <= beat_last;
      end
    end
  end

endmodule

// File: tb/tb_addroundkey_stage.sv
// Testbench for addroundkey_stage: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked by a queue-based reference model of the round rules.
module tb_addroundkey_stage;

  localparam int NR = 10;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] mc_in;
  logic [127:0] sr_in;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic [3:0]   out_round;
  logic         out_last;

  addroundkey_stage #(.NR(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mc_in     (mc_in),
    .sr_in     (sr_in),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .out_round (out_round),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int out_cnt  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [127:0] st;
    int           rnd;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  int           m_rnd = 1;
  logic         hold_prev = 1'b0;
  logic [127:0] prev_state;
  logic [3:0]   prev_round;

  always @(negedge clk) begin
    exp_t e;
    int   r;
    if (!rst_n) begin
      exp_q.delete();
      m_rnd     = 1;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("stall_hold_state", out_state, prev_state);
        chk("stall_hold_round", 128'(out_round), 128'(prev_round));
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 128'(1), 128'(0));
        end else begin
          e = exp_q.pop_front();
          chk("sb_state", out_state, e.st);
          chk("sb_round", 128'(out_round), 128'(e.rnd));
          chk("sb_last", 128'(out_last), 128'(e.last));
        end
      end
      if (in_valid && in_ready) begin
        r      = start ? 1 : m_rnd;
        e.rnd  = r;
        e.last = (r == NR);
        // final round bypasses MixColumns; a start beat is round 1 by definition
        e.st   = (!start && r == NR) ? (sr_in ^ round_key) : (mc_in ^ round_key);
        exp_q.push_back(e);
        m_rnd  = (r == NR) ? 1 : r + 1;
      end else if (start) begin
        m_rnd = 1;
      end
      hold_prev  = out_valid && !out_ready;
      prev_state = out_state;
      prev_round = out_round;
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Present one beat with out_ready high, wait for acceptance, check the registered result.
  task automatic send_beat(input string name, input logic [127:0] mc, input logic [127:0] sr,
                           input logic [127:0] key, input logic st, input logic [127:0] e_state,
                           input logic [3:0] e_round, input logic e_last);
    logic got;
    got       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    start     = st;
    mc_in     = mc;
    sr_in     = sr;
    round_key = key;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk($sformatf("%s accepted", name), 128'(got), 128'(1));
    chk($sformatf("%s valid", name), 128'(out_valid), 128'(1));
    chk($sformatf("%s state", name), out_state, e_state);
    chk($sformatf("%s round", name), 128'(out_round), 128'(e_round));
    chk($sformatf("%s last", name), 128'(out_last), 128'(e_last));
  endtask

  task automatic wait_drain(input string name);
    logic done;
    done      = 1'b0;
    in_valid  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #1;
      done = !out_valid && (exp_q.size() == 0);
    end
    chk($sformatf("%s drained", name), 128'(done), 128'(1));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [127:0] mc;
    logic [127:0] sr;
    logic [127:0] key;
    logic         st;
    logic [127:0] e_state;
    logic [3:0]   e_round;
    logic         e_last;
  } vec_t;

  vec_t vt[11];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           acc;
    logic         fired;
    int           base_cnt;
    logic [127:0] zmc, zkey;

    // Table: round 1 known-answer, rounds 2..9 random, round 10 known-answer, then wrap to 1.
    vt[0] = '{128'h046681e5e0cb199a48f8d37a2806264c, 128'h0, 128'ha0fafe1788542cb123a339392a6c7605,
              1'b1, 128'ha49c7ff2689f352b6b5bea43026a5049, 4'd1, 1'b0};
    for (int i = 1; i <= 8; i++) begin
      vt[i].mc      = rnd128();
      vt[i].sr      = ~vt[i].mc;
      vt[i].key     = rnd128();
      vt[i].st      = 1'b0;
      vt[i].e_state = vt[i].mc ^ vt[i].key;
      vt[i].e_round = 4'(i + 1);
      vt[i].e_last  = 1'b0;
    end
    vt[9] = '{{128{1'b1}}, 128'he9317db5cb322c723d2e895faf090794, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
              1'b0, 128'h3925841d02dc09fbdc118597196a0b32, 4'd10, 1'b1};
    vt[10].mc      = rnd128();
    vt[10].sr      = ~vt[10].mc;
    vt[10].key     = rnd128();
    vt[10].st      = 1'b0;
    vt[10].e_state = vt[10].mc ^ vt[10].key;
    vt[10].e_round = 4'd1;
    vt[10].e_last  = 1'b0;

    // Reset state
    rst_n     = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mc_in     = '0;
    sr_in     = '0;
    round_key = '0;
    #2 rst_n  = 1'b0;
    #1;
    chk("reset out_valid", 128'(out_valid), 128'(0));
    chk("reset out_state", out_state, 128'(0));
    chk("reset out_round", 128'(out_round), 128'(0));
    chk("reset out_last", 128'(out_last), 128'(0));
    chk("reset in_ready", 128'(in_ready), 128'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("release in_ready", 128'(in_ready), 128'(1));

    for (int i = 0; i < 11; i++) begin
      send_beat($sformatf("vec%0d", i), vt[i].mc, vt[i].sr, vt[i].key, vt[i].st,
                vt[i].e_state, vt[i].e_round, vt[i].e_last);
    end
    wait_drain("table");

    // Backpressure: 4 back-to-back beats with out_ready held low at first.
    base_cnt  = out_cnt;
    acc       = 0;
    in_valid  = 1'b1;
    start     = 1'b1;
    mc_in     = rnd128();
    sr_in     = rnd128();
    round_key = rnd128();
    for (int cyc = 0; cyc < 50 && acc < 4; cyc++) begin
      out_ready = (cyc >= 6);
      @(negedge clk);
      fired = in_ready;
      @(posedge clk);
      #1;
      if (fired) begin
        acc++;
        start     = 1'b0;
        mc_in     = rnd128();
        sr_in     = rnd128();
        round_key = rnd128();
      end
      if (cyc == 5) begin
        chk("bp accepted while stalled", 128'(acc), 128'(2));
        chk("bp in_ready low", 128'(in_ready), 128'(0));
        chk("bp out_valid held", 128'(out_valid), 128'(1));
      end
    end
    chk("bp all accepted", 128'(acc), 128'(4));
    wait_drain("backpressure");
    chk("bp beats out", 128'(out_cnt - base_cnt), 128'(4));

    // start coincident with the 7th beat
    for (int i = 0; i < 8; i++) begin
      logic [127:0] m, k;
      m = rnd128();
      k = rnd128();
      send_beat($sformatf("prio%0d", i), m, ~m, k, (i == 0) || (i == 6), m ^ k,
                (i < 6) ? 4'(i + 1) : 4'(i - 5), 1'b0);
    end
    wait_drain("start priority");

    // Randomized traffic against the model
    in_valid = 1'b0;
    start    = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!in_valid) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        start     = ($urandom_range(0, 15) == 0);
        mc_in     = rnd128();
        sr_in     = rnd128();
        round_key = rnd128();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      fired = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (fired) begin
        in_valid = 1'b0;
        start    = 1'b0;
      end
    end
    wait_drain("random");

    // Mid-stream reset with OUT and SKID both full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc       = 0;
    for (int cyc = 0; cyc < 10 && acc < 2; cyc++) begin
      mc_in     = rnd128();
      round_key = rnd128();
      @(negedge clk);
      fired = in_ready;
      @(posedge clk);
      #1;
      if (fired) acc++;
    end
    in_valid = 1'b0;
    chk("rst fill accepted", 128'(acc), 128'(2));
    chk("rst fill in_ready low", 128'(in_ready), 128'(0));
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 128'(out_valid), 128'(0));
    chk("midrst out_state", out_state, 128'(0));
    chk("midrst out_round", 128'(out_round), 128'(0));
    chk("midrst out_last", 128'(out_last), 128'(0));
    chk("midrst in_ready", 128'(in_ready), 128'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("midrst release in_ready", 128'(in_ready), 128'(1));
    zmc  = rnd128();
    zkey = rnd128();
    send_beat("post-reset", zmc, ~zmc, zkey, 1'b0, zmc ^ zkey, 4'd1, 1'b0);
    wait_drain("post-reset");

    // Single beat drained, then idle
    zmc  = rnd128();
    zkey = rnd128();
    send_beat("idle beat", zmc, ~zmc, zkey, 1'b1, zmc ^ zkey, 4'd1, 1'b0);
    @(posedge clk);
    #1;
    chk("idle out_valid", 128'(out_valid), 128'(0));
`ifdef ADDRK_ZEROIZE_EN
    chk("idle out_state cleared", out_state, 128'(0));
    chk("idle out_round cleared", 128'(out_round), 128'(0));
`else
    chk("idle out_state held", out_state, zmc ^ zkey);
    chk("idle out_round held", 128'(out_round), 128'(1));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
